// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: opcodes,
// datapath mux/ALU encodings, FSM states and the packed control vector.
package multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_WB_MEM, S_MEMWR,
    S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_BRANCH, S_JUMP, S_ILLEGAL
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       illegal_op;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/mc_output_decode.sv
// Moore output decoder: state -> datapath control vector. Only FETCH looks
// at mem_ready, so IR/PC latch exactly once when the fetch completes.
module mc_output_decode
  import multicycle_control_pkg::*;
(
  input  logic [3:0]        state,
  input  logic              mem_ready,
  output logic [CTRL_W-1:0] ctrl
);

  ctrl_t c;

  always_comb begin
    c = '0;
    case (state_t'(state))
      S_FETCH: begin
        c.memread  = 1'b1;
        c.alusrcb  = SRCB_FOUR;
        c.aluop    = ALUOP_ADD;
        c.pcsource = PCSRC_ALU;
        c.irwrite  = mem_ready;
        c.pcwrite  = mem_ready;
      end
      S_DECODE: begin
        c.alusrcb = SRCB_IMMSH;
        c.aluop   = ALUOP_ADD;
      end
      S_EXEC_R: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_REG;
        c.aluop   = ALUOP_FUNCT;
      end
      S_WB_R: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      S_EXEC_I, S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALUOP_ADD;
      end
      S_WB_I: c.regwrite = 1'b1;
      S_MEMRD: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      S_WB_MEM: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      S_MEMWR: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca     = 1'b1;
        c.alusrcb     = SRCB_REG;
        c.aluop       = ALUOP_SUB;
        c.pcsource    = PCSRC_ALUOUT;
        c.pcwritecond = 1'b1;
      end
      S_JUMP: begin
        c.pcsource = PCSRC_JUMP;
        c.pcwrite  = 1'b1;
      end
      S_ILLEGAL: c.illegal_op = 1'b1;
      default: c = '0;
    endcase
  end

  assign ctrl = c;

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/mem/writeback
// over a shared memory and ALU, stalls on mem_ready, counts retirements.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSource,
  output logic               illegal_op,
  output logic [COUNT_W-1:0] instr_count
);

  state_t             state, nxt;
  logic               retire;
  logic [CTRL_W-1:0]  raw;
  ctrl_t              c;
  logic [COUNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= nxt;
  end

  always_comb begin
    nxt    = state;
    retire = 1'b0;
    case (state)
      S_FETCH:  if (mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     nxt = S_EXEC_R;
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_BEQ:       nxt = S_BRANCH;
          OP_J:         nxt = S_JUMP;
          OP_ADDI:      nxt = S_EXEC_I;
          default:      nxt = S_ILLEGAL;
        endcase
      end
      S_MEMADR: nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) nxt = S_WB_MEM;
      S_MEMWR: begin
        if (mem_ready) begin
          nxt    = S_FETCH;
          retire = 1'b1;
        end
      end
      S_EXEC_R: nxt = S_WB_R;
      S_EXEC_I: nxt = S_WB_I;
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: begin
        nxt    = S_FETCH;
        retire = 1'b1;
      end
      S_ILLEGAL: nxt = S_FETCH;
      default:   nxt = S_FETCH;
    endcase
  end

  // Wraps naturally at 2^COUNT_W.
  always_ff @(posedge clk) begin
    if (!rst_n)      cnt <= '0;
    else if (retire) cnt <= cnt + 1'b1;
  end

  mc_output_decode u_dec (
    .state     (state),
    .mem_ready (mem_ready),
    .ctrl      (raw)
  );

  // Reset masks every strobe in the same cycle, even mid-stall.
  assign c = rst_n ? ctrl_t'(raw) : '0;

  assign PCWrite     = c.pcwrite;
  assign PCWriteCond = c.pcwritecond;
  assign IorD        = c.iord;
  assign MemRead     = c.memread;
  assign MemWrite    = c.memwrite;
  assign IRWrite     = c.irwrite;
  assign MemtoReg    = c.memtoreg;
  assign RegDst      = c.regdst;
  assign RegWrite    = c.regwrite;
  assign ALUSrcA     = c.alusrca;
  assign ALUSrcB     = c.alusrcb;
  assign ALUOp       = c.aluop;
  assign PCSource    = c.pcsource;
  assign illegal_op  = c.illegal_op;
  assign instr_count = cnt;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed per-cycle vector table for multicycle_control, plus a counter
// wrap sequence. Control bundle order: PW PWC IorD MR MW IRW M2R RD RW SA SB OP PS ILL.
module tb_multicycle_control;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    opcode;
  logic          mem_ready;
  logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic          MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0]    ALUSrcB, ALUOp, PCSource;
  logic [CW-1:0] instr_count;

  always #5 clk = ~clk;

  multicycle_control #(.COUNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .illegal_op(illegal_op), .instr_count(instr_count)
  );

  localparam logic [16:0] ZERO  = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] FET   = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] FETS  = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] DEC   = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] EXR   = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] WBR   = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] EXI   = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] WBI   = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
  localparam logic [16:0] MRD   = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] WBM   = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] MWR   = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] BR    = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] JMP   = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
  localparam logic [16:0] ILL   = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_1;

  typedef struct {
    logic          rst_n;
    logic [5:0]    op;
    logic          rdy;
    logic [16:0]   ctl;
    logic [CW-1:0] cnt;
    string         nm;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic r, logic [5:0] op, logic rdy,
                              logic [16:0] ctl, logic [CW-1:0] cnt, string nm);
    vec_t v;
    v.rst_n = r; v.op = op; v.rdy = rdy; v.ctl = ctl; v.cnt = cnt; v.nm = nm;
    return v;
  endfunction

  // Inputs applied just after posedge, outputs sampled at negedge.
  task automatic apply(input vec_t v, input int idx);
    logic [16:0] got;
    rst_n = v.rst_n; opcode = v.op; mem_ready = v.rdy;
    @(negedge clk);
    got = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};
    n_cmp++;
    if (got !== v.ctl) begin
      n_bad++;
      $display("FAIL [%0d] %s ctl got %b want %b", idx, v.nm, got, v.ctl);
    end
    n_cmp++;
    if (instr_count !== v.cnt) begin
      n_bad++;
      $display("FAIL [%0d] %s instr_count got %0d want %0d", idx, v.nm, instr_count, v.cnt);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = 6'd0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // reset held with mem_ready=1
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 1, ZERO, 0, "reset"));
    // R-type; opcode changes after DECODE must be ignored
    vecs.push_back(mk(1, 0,  1, FET, 0, "r_fetch"));
    vecs.push_back(mk(1, 0,  1, DEC, 0, "r_decode"));
    vecs.push_back(mk(1, 35, 1, EXR, 0, "r_exec"));
    vecs.push_back(mk(1, 35, 1, WBR, 0, "r_wb"));
    // addi
    vecs.push_back(mk(1, 8, 1, FET, 1, "i_fetch"));
    vecs.push_back(mk(1, 8, 1, DEC, 1, "i_decode"));
    vecs.push_back(mk(1, 8, 1, EXI, 1, "i_exec"));
    vecs.push_back(mk(1, 8, 1, WBI, 1, "i_wb"));
    // lw with 2 stall cycles in MEMRD: 7 cycles
    vecs.push_back(mk(1, 35, 1, FET, 2, "lw_fetch"));
    vecs.push_back(mk(1, 35, 1, DEC, 2, "lw_decode"));
    vecs.push_back(mk(1, 35, 1, EXI, 2, "lw_memadr"));
    vecs.push_back(mk(1, 35, 0, MRD, 2, "lw_memrd_stall1"));
    vecs.push_back(mk(1, 35, 0, MRD, 2, "lw_memrd_stall2"));
    vecs.push_back(mk(1, 35, 1, MRD, 2, "lw_memrd_done"));
    vecs.push_back(mk(1, 35, 1, WBM, 2, "lw_wb"));
    // beq with one fetch stall, then j back to back
    vecs.push_back(mk(1, 4, 0, FETS, 3, "beq_fetch_stall"));
    vecs.push_back(mk(1, 4, 1, FET,  3, "beq_fetch"));
    vecs.push_back(mk(1, 4, 1, DEC,  3, "beq_decode"));
    vecs.push_back(mk(1, 4, 1, BR,   3, "beq_branch"));
    vecs.push_back(mk(1, 2, 1, FET,  4, "j_fetch"));
    vecs.push_back(mk(1, 2, 1, DEC,  4, "j_decode"));
    vecs.push_back(mk(1, 2, 1, JMP,  4, "j_jump"));
    // illegal opcode: one pulse, no retire
    vecs.push_back(mk(1, 63, 1, FET, 5, "ill_fetch"));
    vecs.push_back(mk(1, 63, 1, DEC, 5, "ill_decode"));
    vecs.push_back(mk(1, 63, 1, ILL, 5, "ill_pulse"));
    // sw, zero wait
    vecs.push_back(mk(1, 43, 1, FET, 5, "sw_fetch"));
    vecs.push_back(mk(1, 43, 1, DEC, 5, "sw_decode"));
    vecs.push_back(mk(1, 43, 1, EXI, 5, "sw_memadr"));
    vecs.push_back(mk(1, 43, 1, MWR, 5, "sw_memwr"));
    // sw with reset dropped mid-stall
    vecs.push_back(mk(1, 43, 1, FET,  6, "swr_fetch"));
    vecs.push_back(mk(1, 43, 1, DEC,  6, "swr_decode"));
    vecs.push_back(mk(1, 43, 1, EXI,  6, "swr_memadr"));
    vecs.push_back(mk(1, 43, 0, MWR,  6, "swr_stall"));
    vecs.push_back(mk(0, 43, 0, ZERO, 6, "swr_reset_cycle"));
    vecs.push_back(mk(1, 0,  1, FET,  0, "swr_restart"));
    vecs.push_back(mk(1, 0,  1, DEC,  0, "swr_restart_decode"));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // counter wrap: fresh reset, then 8 jumps on a 3-bit counter
    apply(mk(0, 2, 1, ZERO, 0, "wrap_reset"), 100);
    for (int k = 0; k < 8; k++) begin
      apply(mk(1, 2, 1, FET, 3'(k), "wrap_fetch"), 101 + 3 * k);
      apply(mk(1, 2, 1, DEC, 3'(k), "wrap_decode"), 102 + 3 * k);
      apply(mk(1, 2, 1, JMP, 3'(k), "wrap_jump"), 103 + 3 * k);
    end
    apply(mk(1, 0, 0, FETS, 0, "wrap_done"), 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
